// File: rtl/aud_sample_prefetch.sv
// Audio sample prefetcher: streams 16-bit PCM words from SDRAM into a small FIFO and
// hands one sample per serializer strobe, substituting silence and counting underruns.
module aud_sample_prefetch #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          LOOP       = 1'b1
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [24:0]                   addr_start,
  input  logic [24:0]                   addr_end,
  output logic                          ram_rden,
  output logic [24:0]                   ram_addr,
  input  logic [15:0]                   ram_data,
  input  logic                          ram_ack,
  input  logic                          sample_req,
  output logic [15:0]                   sample_out,
  output logic                          sample_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt,
  output logic                          done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StWaitAck, StDone} state_e;

  state_e          state_q;
  logic [24:0]     start_q;
  logic [24:0]     end_q;
  logic            abort_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic ack_seen;
  logic drop;
  logic push;
  logic pop;
  logic underrun;
  logic flush;

  always_comb begin
    ack_seen = (state_q == StWaitAck) && ram_ack;
    // Once enable has dropped during a transaction, the returned word is thrown away.
    drop     = abort_q || !enable;
    push     = ack_seen && !drop;
    pop      = sample_req && (fifo_level != '0);
    underrun = sample_req && (fifo_level == '0);
    flush    = (((state_q == StFetch) || (state_q == StDone)) && !enable) ||
               (ack_seen && drop);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ram_rden <= 1'b0;
      ram_addr <= '0;
      done     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            start_q  <= addr_start;
            // An inverted range collapses to the single word at addr_start.
            end_q    <= (addr_end < addr_start) ? addr_start : addr_end;
            ram_addr <= addr_start;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (fifo_level < LvlFull) begin
            ram_rden <= 1'b1;
            abort_q  <= 1'b0;
            state_q  <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (!enable) begin
            abort_q <= 1'b1;
          end
          if (ram_ack) begin
            ram_rden <= 1'b0;
            if (drop) begin
              state_q <= StIdle;
            end else if (ram_addr == end_q) begin
              if (LOOP) begin
                ram_addr <= start_q;
                state_q  <= StFetch;
              end else begin
                done    <= 1'b1;
                state_q <= StDone;
              end
            end else begin
              ram_addr <= ram_addr + 25'd1;
              state_q  <= StFetch;
            end
          end
        end
        StDone: begin
          if (!enable) begin
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_valid <= sample_req;
      if (pop) begin
        sample_out <= mem_q[rd_ptr_q];
      end else if (underrun) begin
        sample_out <= '0;
      end
      if (underrun && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_level <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        fifo_level <= fifo_level + LvlW'(push) - LvlW'(pop);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ram_data;
    end
  end

endmodule

// File: tb/tb_aud_sample_prefetch.sv
// Bench for aud_sample_prefetch: a looping instance driven by a 3-cycle arbiter model with a
// sample scoreboard, plus a non-looping instance exercised by hand-driven acknowledges.
module tb_aud_sample_prefetch;

  logic clk50 = 1'b0;
  logic reset;
  always #10 clk50 = ~clk50;

  logic        enable;
  logic [24:0] addr_start, addr_end, ram_addr;
  logic        ram_rden, ram_ack, sample_req, sample_valid, done;
  logic [15:0] ram_data, sample_out, underrun_cnt;
  logic [4:0]  fifo_level;

  logic        en_b, rden_b, ack_b, req_b, valid_b, done_b;
  logic [24:0] as_b, ae_b, addr_b;
  logic [15:0] data_b, out_b, und_b;
  logic [4:0]  lvl_b;

  aud_sample_prefetch #(.FIFO_DEPTH(16), .LOOP(1'b1)) u_dut (
    .clk50(clk50), .reset(reset), .enable(enable), .addr_start(addr_start),
    .addr_end(addr_end), .ram_rden(ram_rden), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ack(ram_ack), .sample_req(sample_req), .sample_out(sample_out),
    .sample_valid(sample_valid), .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .done(done)
  );

  aud_sample_prefetch #(.FIFO_DEPTH(16), .LOOP(1'b0)) u_dut_b (
    .clk50(clk50), .reset(reset), .enable(en_b), .addr_start(as_b), .addr_end(ae_b),
    .ram_rden(rden_b), .ram_addr(addr_b), .ram_data(data_b), .ram_ack(ack_b),
    .sample_req(req_b), .sample_out(out_b), .sample_valid(valid_b), .fifo_level(lvl_b),
    .underrun_cnt(und_b), .done(done_b)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference FIFO contents, expected sample stream and expected underruns.
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  int          exp_under = 0;
  logic        ack_keep = 1'b0;
  logic        stall = 1'b0;
  logic [24:0] m_start = '0, m_end = '0, m_next = '0;

  always @(posedge clk50) begin
    if (!reset) begin
      if (sample_req) begin
        if (mq.size() > 0) exp_q.push_back(mq.pop_front());
        else begin
          exp_q.push_back(16'h0000);
          exp_under++;
        end
      end
      if (ram_ack && ack_keep) mq.push_back(ram_data);
    end
  end

  always @(negedge clk50) begin
    if (!reset && sample_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sample_valid_extra: got valid with data 0x%0h, expected no valid",
                 sample_out);
      end else begin
        chk("sample_out", {16'h0, sample_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Arbiter: acks 3 cycles after ram_rden rises, data = address, unless stalled.
  initial begin : arbiter
    int cnt;
    cnt = 0;
    ram_ack = 1'b0;
    ram_data = '0;
    forever begin
      @(negedge clk50);
      #1;
      ram_ack = 1'b0;
      if (ram_rden && !reset) begin
        cnt++;
        if (cnt >= 3 && !stall) begin
          ram_ack  = 1'b1;
          ram_data = ram_addr[15:0];
          ack_keep = enable;
          chk("fetch_addr", {7'h0, ram_addr}, {7'h0, m_next});
          m_next = (m_next == m_end) ? m_start : m_next + 25'd1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic pulse_req();
    sample_req = 1'b1;
    @(negedge clk50);
    sample_req = 1'b0;
  endtask

  task automatic wait_level(input logic [4:0] lvl, input int limit, input string nm);
    int t = 0;
    while (fifo_level != lvl && t < limit) begin
      @(negedge clk50);
      t++;
    end
    chk(nm, {27'h0, fifo_level}, {27'h0, lvl});
  endtask

  task automatic ack_b_once(input logic [24:0] exp_addr, input string nm);
    int t = 0;
    while (!rden_b && t < 50) begin
      @(negedge clk50);
      t++;
    end
    chk({nm, "_rden"}, {31'h0, rden_b}, 32'h1);
    chk(nm, {7'h0, addr_b}, {7'h0, exp_addr});
    @(negedge clk50);
    ack_b  = 1'b1;
    data_b = exp_addr[15:0];
    @(negedge clk50);
    ack_b  = 1'b0;
  endtask

  initial begin
    int hi;
    int t;
    reset = 1'b1;
    enable = 1'b0; addr_start = '0; addr_end = '0; sample_req = 1'b0;
    en_b = 1'b0; as_b = '0; ae_b = '0; ack_b = 1'b0; data_b = '0; req_b = 1'b0;
    #35 reset = 1'b0;

    // 1: idle after reset
    cyc(10);
    chk("rst_rden", {31'h0, ram_rden}, 32'h0);
    chk("rst_level", {27'h0, fifo_level}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_sample_out", {16'h0, sample_out}, 32'h0);
    chk("rst_underrun", {16'h0, underrun_cnt}, 32'h0);
    chk("rst_addr", {7'h0, ram_addr}, 32'h0);

    // 2: fill from 0x100
    m_start = 25'h100; m_end = 25'h1FF; m_next = 25'h100;
    addr_start = 25'h100; addr_end = 25'h1FF; enable = 1'b1;
    wait_level(5'd16, 400, "fill_level");
    hi = 0;
    repeat (10) begin
      @(negedge clk50);
      if (ram_rden) hi++;
    end
    chk("rden_while_full", hi, 0);
    chk("next_addr_full", {7'h0, ram_addr}, 32'h110);

    // 3: slow drain with refill
    repeat (16) begin
      chk("level_ge12", {31'h0, fifo_level >= 5'd12}, 32'h1);
      pulse_req();
      cyc(7);
    end
    chk("no_underrun", {16'h0, underrun_cnt}, 32'h0);

    // 4: arbiter stall, FIFO drains into underruns
    wait_level(5'd16, 100, "refill_level");
    stall = 1'b1;
    repeat (24) begin
      pulse_req();
      cyc(1);
    end
    chk("drained_level", {27'h0, fifo_level}, 32'h0);
    chk("stall_underrun", {16'h0, underrun_cnt}, 32'd8);
    chk("stall_underrun_model", {16'h0, underrun_cnt}, exp_under);
    stall = 1'b0;
    cyc(150);

    // 5: stop, then loop over 0x10..0x12
    enable = 1'b0;
    cyc(10);
    chk("stop_level", {27'h0, fifo_level}, 32'h0);
    chk("stop_rden", {31'h0, ram_rden}, 32'h0);
    mq.delete();
    m_start = 25'h10; m_end = 25'h12; m_next = 25'h10;
    addr_start = 25'h10; addr_end = 25'h12; enable = 1'b1;
    wait_level(5'd16, 400, "loop_fill_level");
    repeat (6) begin
      pulse_req();
      cyc(7);
    end

    // 6: drop enable mid-transaction
    wait_level(5'd16, 200, "loop_refill_level");
    stall = 1'b1;
    pulse_req();
    t = 0;
    while (!ram_rden && t < 20) begin
      @(negedge clk50);
      t++;
    end
    chk("abort_rden_up", {31'h0, ram_rden}, 32'h1);
    enable = 1'b0;
    cyc(5);
    chk("abort_rden_held", {31'h0, ram_rden}, 32'h1);
    chk("abort_addr_held", {7'h0, ram_addr}, {7'h0, m_next});
    chk("abort_level_before", {27'h0, fifo_level}, 32'd15);
    stall = 1'b0;
    @(negedge clk50);
    chk("abort_flush_level", {27'h0, fifo_level}, 32'h0);
    chk("abort_rden_low", {31'h0, ram_rden}, 32'h0);
    mq.delete();
    cyc(3);
    pulse_req();
    cyc(2);
    chk("idle_underrun", {16'h0, underrun_cnt}, 32'd9);
    m_next = 25'h10;
    enable = 1'b1;
    t = 0;
    while (mq.size() < 2 && t < 100) begin
      @(negedge clk50);
      t++;
    end
    chk("restart_fetched", mq.size() >= 2, 32'h1);
    pulse_req();
    cyc(3);
    pulse_req();
    cyc(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_underrun", {16'h0, underrun_cnt}, exp_under);

    // LOOP=0 instance: stop after the last word
    as_b = 25'h10; ae_b = 25'h12; en_b = 1'b1;
    ack_b_once(25'h10, "b_addr0");
    ack_b_once(25'h11, "b_addr1");
    ack_b_once(25'h12, "b_addr2");
    chk("b_done", {31'h0, done_b}, 32'h1);
    chk("b_level", {27'h0, lvl_b}, 32'd3);
    hi = 0;
    repeat (10) begin
      @(negedge clk50);
      if (rden_b) hi++;
    end
    chk("b_no_rden_done", hi, 0);
    ack_b = 1'b1;
    @(negedge clk50);
    ack_b = 1'b0;
    @(negedge clk50);
    chk("b_stray_ack", {27'h0, lvl_b}, 32'd3);
    req_b = 1'b1;
    @(negedge clk50);
    req_b = 1'b0;
    chk("b_valid", {31'h0, valid_b}, 32'h1);
    chk("b_sample", {16'h0, out_b}, 32'h10);
    en_b = 1'b0;
    cyc(2);
    chk("b_done_clr", {31'h0, done_b}, 32'h0);
    chk("b_flush", {27'h0, lvl_b}, 32'h0);
    as_b = 25'h20; ae_b = 25'h05; en_b = 1'b1;
    ack_b_once(25'h20, "b_inv_addr");
    chk("b_inv_done", {31'h0, done_b}, 32'h1);
    hi = 0;
    repeat (5) begin
      @(negedge clk50);
      if (rden_b) hi++;
    end
    chk("b_inv_no_rden", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
